// File: rtl/seg7_sum_mux_display.sv
// seg7_sum_mux_display: sums two operands, converts them to BCD by sequential double-dabble, and scans a common-anode 7-seg display.
// Optional LEADING_ZERO_BLANK_EN blanks the zero digits above the most significant nonzero digit.
module seg7_sum_mux_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_1,
    input  logic [WIDTH-1:0]  in_2,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        display_1,
    output logic              dp
);
    localparam int SW  = WIDTH + 1;
    localparam int NIB = (SW * 302 + 999) / 1000;
    localparam int NB  = NIB > DIGITS ? NIB : DIGITS;
    localparam int BB  = NB * 4;
    localparam int NW  = $clog2(SW + 1);
    localparam int CW  = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic {IDLE, CONV} state_t;
    state_t              st_q, st_d;
    logic [BB+SW-1:0]    sr_q, sr_d, adj;
    logic [NW-1:0]       n_q, n_d;
    logic [DIGITS*4-1:0] val_q, val_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [3:0]          dig;
    logic                blank, wrap;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0: enc = 7'b1000000;
            4'd1: enc = 7'b1111001;
            4'd2: enc = 7'b0100100;
            4'd3: enc = 7'b0110000;
            4'd4: enc = 7'b0011001;
            4'd5: enc = 7'b0010010;
            4'd6: enc = 7'b0000010;
            4'd7: enc = 7'b1111000;
            4'd8: enc = 7'b0000000;
            4'd9: enc = 7'b0010000;
            default: enc = 7'h7F;
        endcase
    endfunction

    always_comb begin
        adj = sr_q;
        for (int k = 0; k < NB; k++)
            if (sr_q[SW+4*k +: 4] >= 4'd5) adj[SW+4*k +: 4] = sr_q[SW+4*k +: 4] + 4'd3;
        st_d  = st_q;
        sr_d  = sr_q;
        n_d   = n_q;
        val_d = val_q;
        ovf_d = ovf_q;
        if (st_q == IDLE) begin
            if (load) begin
                st_d = CONV;
                sr_d = {{BB{1'b0}}, {1'b0, in_1} + {1'b0, in_2}};
                n_d  = NW'(SW);
            end
        end else begin
            sr_d = adj << 1;
            n_d  = n_q - 1'b1;
            // Display value is only replaced once the whole conversion is done
            if (n_q == NW'(1)) begin
                st_d  = IDLE;
                val_d = sr_d[SW +: DIGITS*4];
                ovf_d = |(sr_d >> (SW + DIGITS*4));
            end
        end
    end

    always_comb begin
        wrap  = cnt_q == CW'(REFRESH_DIV - 1);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        dig   = val_q[4*idx_q +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = idx_q != '0 && !ovf_q && (val_q >> (4*idx_q)) == '0;
`else
        blank = 1'b0;
`endif
        an_d  = wrap ? ~(DIGITS'(1) << idx_q) : an_q;
        seg_d = wrap ? (ovf_q ? 7'b0111111 : blank ? 7'h7F : enc(dig)) : seg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            sr_q  <= '0;
            n_q   <= '0;
            val_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= 7'h7F;
        end else begin
            st_q  <= st_d;
            sr_q  <= sr_d;
            n_q   <= n_d;
            val_q <= val_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign busy      = st_q == CONV;
    assign ovf       = ovf_q;
    assign an        = an_q;
    assign display_1 = seg_q;
    assign dp        = 1'b1;
endmodule

// File: tb/tb_seg7_sum_mux_display.sv
// tb_seg7_sum_mux_display: scoreboard bench; results are checked by scanning the multiplexed digits after each conversion.
module tb_seg7_sum_mux_display;
    localparam int RD = 4;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000,
                           S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000,
                           DS = 7'b0111111, BL = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z = BL;
`else
    localparam logic [6:0] Z = S0;
`endif
    typedef struct packed {
        logic            ovf;
        logic [3:0][6:0] seg;
    } exp_t;

    logic clk = 0, rst_n = 0;
    logic [7:0] a1 = 0, a2 = 0, b1 = 0, b2 = 0;
    logic load_a = 0, load_b = 0;
    logic busy_a, ovf_a, dp_a, busy_b, ovf_b, dp_b;
    logic [3:0] an_a;
    logic [1:0] an_b;
    logic [6:0] seg_a, seg_b;
    int vec = 0, fails = 0;
    exp_t qa[$], qb[$];

    always #5 clk = ~clk;

    seg7_sum_mux_display #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(RD)) u_a (
        .clk(clk), .rst_n(rst_n), .in_1(a1), .in_2(a2), .load(load_a),
        .busy(busy_a), .ovf(ovf_a), .an(an_a), .display_1(seg_a), .dp(dp_a));
    seg7_sum_mux_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(RD)) u_b (
        .clk(clk), .rst_n(rst_n), .in_1(b1), .in_2(b2), .load(load_b),
        .busy(busy_b), .ovf(ovf_b), .an(an_b), .display_1(seg_b), .dp(dp_b));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] cur_an(input int d);
        return d != 0 ? {2'b11, an_b} : an_a;
    endfunction

    task automatic scan(input int d, input exp_t e);
        logic [3:0][6:0] got;
        logic [3:0] a0, ac;
        int nd, t;
        nd = d != 0 ? 2 : 4;
        got = '1;
        chk($sformatf("ovf dut%0d", d), d != 0 ? ovf_b : ovf_a, e.ovf);
        a0 = cur_an(d);
        t = 0;
        while (cur_an(d) == a0 && t < 3*RD) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("refresh timeout dut%0d", d), t < 3*RD, 1);
        repeat (nd*RD) begin
            ac = cur_an(d);
            for (int i = 0; i < nd; i++) if (!ac[i]) got[i] = d != 0 ? seg_b : seg_a;
            @(negedge clk);
        end
        for (int i = 0; i < nd; i++) chk($sformatf("dut%0d digit%0d", d, i), got[i], e.seg[i]);
    endtask

    initial begin
        logic pb = 0;
        forever begin
            @(negedge clk);
            if (pb && !busy_a && rst_n) begin
                if (qa.size() == 0) chk("unexpected result dut0", 1, 0);
                else scan(0, qa.pop_front());
            end
            pb = busy_a;
        end
    end

    initial begin
        logic pb = 0;
        forever begin
            @(negedge clk);
            if (pb && !busy_b && rst_n) begin
                if (qb.size() == 0) chk("unexpected result dut1", 1, 0);
                else scan(1, qb.pop_front());
            end
            pb = busy_b;
        end
    end

    task automatic go(input int d, input logic [7:0] x, input logic [7:0] y, input exp_t e);
        @(negedge clk);
        if (d != 0) begin qb.push_back(e); b1 = x; b2 = y; load_b = 1; end
        else begin qa.push_back(e); a1 = x; a2 = y; load_a = 1; end
        @(negedge clk);
        load_a = 0;
        load_b = 0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset busy", busy_a, 0);
        chk("reset an", an_a, 4'hF);
        chk("reset seg", seg_a, BL);
        chk("reset ovf", ovf_a, 0);
        chk("dp off", dp_a, 1);
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("an before first wrap", an_a, 4'hF);
        @(posedge clk);
        #1 chk("first wrap an", an_a, 4'hE);
        chk("first wrap seg", seg_a, S0);
        // 200+55 with a second load 3 cycles into the conversion
        @(negedge clk);
        qa.push_back('{ovf: 0, seg: {Z, S2, S5, S5}});
        a1 = 200; a2 = 55; load_a = 1;
        @(negedge clk);
        n = 0;
        while (busy_a && n < 20) begin
            n++;
            if (n == 3) begin a1 = 1; a2 = 1; load_a = 1; end
            else load_a = 0;
            @(negedge clk);
        end
        load_a = 0;
        chk("busy cycles", n, 9);
        repeat (40) @(negedge clk);
        go(0, 123, 200, '{ovf: 0, seg: {Z, S3, S2, S3}});
        go(0, 255, 255, '{ovf: 0, seg: {Z, S5, S1, S0}});
        go(0, 0, 7, '{ovf: 0, seg: {Z, Z, Z, S7}});
        go(0, 0, 0, '{ovf: 0, seg: {Z, Z, Z, S0}});
        go(1, 99, 1, '{ovf: 1, seg: {BL, BL, DS, DS}});
        go(1, 99, 0, '{ovf: 0, seg: {BL, BL, S9, S9}});
        go(1, 40, 2, '{ovf: 0, seg: {BL, BL, S4, S2}});
        // Reset three cycles into a conversion
        @(negedge clk);
        a1 = 100; a2 = 100; load_a = 1;
        @(negedge clk);
        load_a = 0;
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1 chk("abort busy", busy_a, 0);
        chk("abort an", an_a, 4'hF);
        chk("abort seg", seg_a, BL);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (4) @(posedge clk);
        #1 chk("post-abort an0", an_a, 4'hE);
        chk("post-abort digit0", seg_a, S0);
        repeat (4) @(posedge clk);
        #1 chk("post-abort an1", an_a, 4'hD);
        chk("post-abort digit1", seg_a, Z);
        chk("pending results dut0", qa.size(), 0);
        chk("pending results dut1", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end
endmodule
